// File: rtl/nmux_pkg.sv
// Shared helpers for the nmux selector family: select-width math, buffer depth
// and the in_bus channel slicing rule.
package nmux_pkg;

   localparam int BUF_DEPTH = 2;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Channel k of a flattened bus sits at bits [k*w +: w].
   function automatic int chan_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/nmux_sel.sv
// Combinational NUM_IN:1 WIDTH-bit selector; an out-of-range select yields
// zero data and raises oor.
module nmux_sel
   import nmux_pkg::*;
#(
   parameter  int WIDTH  = 5,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        data,
   output logic                    oor
);

   always_comb begin
      data = '0;
      oor  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            data = in_bus[chan_lsb(k, WIDTH) +: WIDTH];
            oor  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/nmux_buf.sv
// N-way selector feeding a registered 2-entry valid/ready buffer.
// Optional NMUX_BUF_ERRCNT_EN adds a saturating err_cnt of out-of-range selects.
module nmux_buf
   import nmux_pkg::*;
#(
   parameter  int WIDTH  = 5,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
`ifdef NMUX_BUF_ERRCNT_EN
   ,
   output logic [7:0]              err_cnt
`endif
);

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   logic [WIDTH-1:0] sel_data;
   logic             sel_oor;
   logic             push;
   logic             pop;

   logic [WIDTH-1:0] entry_q [BUF_DEPTH];
   logic [WIDTH-1:0] entry_d [BUF_DEPTH];
   logic [1:0]       count_q, count_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             sel_err_q, sel_err_d;
`ifdef NMUX_BUF_ERRCNT_EN
   logic [7:0]       err_cnt_q, err_cnt_d;
`endif

   nmux_sel #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_sel (
      .in_bus (in_bus),
      .sel    (sel),
      .data   (sel_data),
      .oor    (sel_oor)
   );

   // Ready depends on the count register only: no ready-to-ready path.
   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = out_valid ? entry_q[head_q] : '0;
   assign sel_err   = sel_err_q;
`ifdef NMUX_BUF_ERRCNT_EN
   assign err_cnt   = err_cnt_q;
`endif

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      entry_d   = entry_q;
      count_d   = count_q;
      head_d    = head_q;
      tail_d    = tail_q;
      sel_err_d = 1'b0;
`ifdef NMUX_BUF_ERRCNT_EN
      err_cnt_d = err_cnt_q;
`endif
      if (push) begin
         entry_d[tail_q] = sel_data;
         tail_d          = ~tail_q;
         sel_err_d       = sel_oor;
`ifdef NMUX_BUF_ERRCNT_EN
         if (sel_oor && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
`endif
      end
      if (pop) begin
         head_d = ~head_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         count_q   <= 2'd0;
         head_q    <= 1'b0;
         tail_q    <= 1'b0;
         sel_err_q <= 1'b0;
`ifdef NMUX_BUF_ERRCNT_EN
         err_cnt_q <= 8'd0;
`endif
      end else begin
         entry_q   <= entry_d;
         count_q   <= count_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         sel_err_q <= sel_err_d;
`ifdef NMUX_BUF_ERRCNT_EN
         err_cnt_q <= err_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_nmux_buf.sv
// Bench for nmux_buf: a 4-input and a 3-input instance share one stimulus
// stream and are each compared against a queue-based model.
module tb_nmux_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] in_bus;
   logic [1:0]  sel;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready4, out_valid4, sel_err4;
   logic [4:0]  out_data4;
   logic        in_ready3, out_valid3, sel_err3;
   logic [4:0]  out_data3;
`ifdef NMUX_BUF_ERRCNT_EN
   logic [7:0]  err_cnt4, err_cnt3;
`endif

   int tests = 0;
   int fails = 0;
   int q4[$];
   int q3[$];
   bit esel4, esel3;
   int ecnt4, ecnt3;
   bit blocked;

   always #5 clk = ~clk;

   nmux_buf #(.WIDTH(5), .NUM_IN(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bus    (in_bus),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .sel_err   (sel_err4)
`ifdef NMUX_BUF_ERRCNT_EN
      ,
      .err_cnt   (err_cnt4)
`endif
   );

   nmux_buf #(.WIDTH(5), .NUM_IN(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bus    (in_bus[14:0]),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready),
      .sel_err   (sel_err3)
`ifdef NMUX_BUF_ERRCNT_EN
      ,
      .err_cnt   (err_cnt3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Channel value the spec says is stored: channel[s], or 0 when s >= n.
   function automatic int chan_val(input logic [19:0] b, input int s, input int n);
      if (s >= n) return 0;
      return int'((b >> (s * 5)) & 20'h1F);
   endfunction

   task automatic check_all();
      check("in_ready4",  32'(in_ready4),  32'(q4.size() != 2));
      check("out_valid4", 32'(out_valid4), 32'(q4.size() != 0));
      check("out_data4",  32'(out_data4),  32'((q4.size() != 0) ? q4[0] : 0));
      check("sel_err4",   32'(sel_err4),   32'(esel4));
      check("in_ready3",  32'(in_ready3),  32'(q3.size() != 2));
      check("out_valid3", 32'(out_valid3), 32'(q3.size() != 0));
      check("out_data3",  32'(out_data3),  32'((q3.size() != 0) ? q3[0] : 0));
      check("sel_err3",   32'(sel_err3),   32'(esel3));
`ifdef NMUX_BUF_ERRCNT_EN
      check("err_cnt4",   32'(err_cnt4),   32'(ecnt4));
      check("err_cnt3",   32'(err_cnt3),   32'(ecnt3));
`endif
   endtask

   task automatic model_clear();
      q4.delete();
      q3.delete();
      esel4 = 1'b0;
      esel3 = 1'b0;
      ecnt4 = 0;
      ecnt3 = 0;
   endtask

   task automatic model_edge(input bit v, input int s, input bit r);
      bit push4, pop4, push3, pop3;
      push4 = v && (q4.size() < 2);
      pop4  = r && (q4.size() > 0);
      push3 = v && (q3.size() < 2);
      pop3  = r && (q3.size() > 0);
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(chan_val(in_bus, s, 4));
      if (pop3) void'(q3.pop_front());
      if (push3) q3.push_back(chan_val(in_bus, s, 3));
      esel4 = push4 && (s >= 4);
      esel3 = push3 && (s >= 3);
      if (esel4 && ecnt4 < 255) ecnt4++;
      if (esel3 && ecnt3 < 255) ecnt3++;
   endtask

   // Apply inputs, check outputs mid-cycle, then advance one clock edge.
   task automatic step(input bit v, input int s, input bit r);
      in_valid  = v;
      sel       = 2'(s);
      out_ready = r;
      #1;
      check_all();
      blocked = v && (q4.size() == 2);
      @(posedge clk);
      model_edge(v, s, r);
      #1;
   endtask

   initial begin
      bit rv;
      int rs;
      rst_n     = 1'b0;
      in_bus    = '0;
      sel       = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_clear();
      #12;
      check_all();
      check("reset_in_ready", 32'(in_ready4), 32'd1);
      rst_n = 1'b1;

      // single transfer
      in_bus = {5'd3, 5'd2, 5'd1, 5'd0};
      step(1'b1, 2, 1'b1);
      check("t1_data", 32'(out_data4), 32'd2);
      check("t1_valid", 32'(out_valid4), 32'd1);
      step(1'b0, 0, 1'b1);
      check("t1_drain", 32'(out_valid4), 32'd0);

      // back-pressure
      step(1'b1, 1, 1'b0);
      step(1'b1, 3, 1'b0);
      check("bp_full_ready", 32'(in_ready4), 32'd0);
      step(1'b0, 0, 1'b0);
      check("bp_hold", 32'(out_data4), 32'd1);
      step(1'b0, 0, 1'b1);
      check("bp_pop2", 32'(out_data4), 32'd3);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);

      // streaming
      for (int i = 0; i < 8; i++) begin
         step(1'b1, i % 4, 1'b1);
         check("stream_data", 32'(out_data4), 32'(i % 4));
      end
      step(1'b0, 0, 1'b1);

      // out-of-range on the 3-input instance
      in_bus = {5'd7, 5'd9, 5'd10, 5'd11};
      step(1'b1, 3, 1'b1);
      check("oor_err", 32'(sel_err3), 32'd1);
      check("oor_data", 32'(out_data3), 32'd0);
      check("oor_data4", 32'(out_data4), 32'd7);
      step(1'b0, 0, 1'b1);
      check("oor_err_clr", 32'(sel_err3), 32'd0);
      step(1'b0, 0, 1'b1);

      // asynchronous reset while full
      step(1'b1, 1, 1'b0);
      step(1'b1, 2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all();
      check("mrst_valid", 32'(out_valid4), 32'd0);
      check("mrst_ready", 32'(in_ready4), 32'd1);
      rst_n = 1'b1;
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);

`ifdef NMUX_BUF_ERRCNT_EN
      // counter saturation
      repeat (260) step(1'b1, 3, 1'b1);
      step(1'b0, 0, 1'b1);
      check("sat_cnt", 32'(err_cnt3), 32'd255);
      step(1'b1, 3, 1'b1);
      step(1'b0, 0, 1'b1);
      check("sat_hold", 32'(err_cnt3), 32'd255);
`endif

      // randomized traffic; a refused offer is held until accepted
      blocked = 1'b0;
      rv = 1'b0;
      rs = 0;
      for (int i = 0; i < 400; i++) begin
         if (!blocked) begin
            in_bus = 20'($urandom);
            rv     = bit'($urandom_range(0, 1));
            rs     = int'($urandom_range(0, 3));
         end
         step(rv, rs, $urandom_range(0, 3) != 0);
      end
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      check_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nmux_buf.md
Name: nmux_buf

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered 2-entry output buffer and a valid/ready handshake on both sides.
- Generation-2 replacement for the fixed two-input datapath selectors in the multicycle CPU, e.g. RegDst, ALUSrc and PC-source selection.
- Decouples select timing from consumer timing, so a stalled consumer never loses a selected value.
- Flags out-of-range selects instead of silently aliasing them.

Parameters:
- WIDTH, 5: data width of each input channel and of out_data.
- NUM_IN, 4: number of input channels, minimum 2.
- SEL_W, $clog2(NUM_IN): select width. Localparam, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_bus  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index, sampled with in_valid.
- in_valid  input  1  producer offers in_bus/sel this cycle.
- in_ready  output  1  buffer can accept this cycle.
- out_data  output  WIDTH  head-of-buffer value.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- sel_err  output  1  one-cycle pulse: an accepted sel was >= NUM_IN.

Behaviour:
- Clock and reset: single clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: count=0, head=0, tail=0, both entries=0, out_valid=0, out_data=0, sel_err=0.
- Reset asserted mid-transfer discards all buffered data. No partial state survives.
- in_ready = (count != 2). It is combinational from the count register only and never depends on out_ready, so there is no combinational ready-to-ready path.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Push action: at the clk edge, entry[tail] <= channel[sel], then tail toggles.
- Out-of-range sel (sel >= NUM_IN, possible only when NUM_IN is not a power of 2):
  - entry[tail] <= 0.
  - sel_err <= 1 for exactly one cycle.
  - The push still completes normally.
- sel_err <= 0 on every cycle that has no out-of-range push.
- Pop action: at the clk edge, head toggles.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- out_valid = (count != 0).
- out_data = entry[head] when out_valid, else forced to 0.
- Latency: a value pushed at edge t appears on out_data with out_valid=1 in the cycle after edge t (1-cycle latency) when the buffer was empty.
- Full (count=2): in_ready=0. The producer must hold in_valid, in_bus and sel until accepted. A pop in the full cycle frees a slot, so in_ready=1 in the next cycle.
- Empty (count=0): out_valid=0, and out_ready is ignored.
- Simultaneous push and pop at count=1: the head advances to the new entry and count stays 1. Sustained throughput is one transfer per cycle.
- out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- head and tail are 1-bit pointers that wrap 1->0.

Optional Feature:
- Macro: NMUX_BUF_ERRCNT_EN.
- When defined:
  - Adds output port err_cnt [7:0]: a saturating count of accepted out-of-range selects.
  - Reset value 0.
  - Increments on the same edge that sets sel_err.
  - Holds at 255 once reached.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package nmux_pkg holds:
  - the clog2 helper function;
  - localparam BUF_DEPTH = 2;
  - the channel-slice macro/function used for in_bus indexing.
- Natural sub-module: nmux_sel, a purely combinational N:1 WIDTH-bit select that returns 0 and an out-of-range flag. It is reused by the existing fixed selectors in later cleanup.
- nmux_buf instantiates one nmux_sel plus the 2-entry buffer logic.

Test Plan:
- Reset / single transfer: reset asserted, then rst_n=1 with NUM_IN=4, WIDTH=5, in_bus={5'd3,5'd2,5'd1,5'd0}, sel=2, out_ready=1 -> after one edge out_data=5'd2, out_valid=1; the next cycle out_valid=0.
- Back-pressure: out_ready=0, push sel=1 then sel=3 -> in_ready=0 after the 2nd push; out_data=1 held; raise out_ready -> pops 1 then 3 in order.
- Streaming: out_ready=1 with a continuous push every cycle, sel cycling 0..3 -> out_data sequence 0,1,2,3 with no bubbles; count never exceeds 1.
- Out-of-range: NUM_IN=3, push sel=3 -> stored value 0; sel_err high exactly one cycle; with NMUX_BUF_ERRCNT_EN, err_cnt=1.
- Mid-operation reset: buffer full, rst_n pulsed low asynchronously between edges -> out_valid=0, out_data=0 and in_ready=1 immediately; no stale data after release.
- Saturation (NMUX_BUF_ERRCNT_EN only): 260 out-of-range pushes -> err_cnt=255 and stays there.
